// File: rtl/bcd_modulo_counter.sv
// ---------------------------------------------------------------------------
// bcd_modulo_counter
//   Multi-digit BCD counter that counts up or down modulo MAX_COUNT, with
//   synchronous clear, parallel load with range checking and a combinational
//   carry/borrow output so several instances can be chained into a timebase.
//
// Parameters
//   NUM_DIGITS  number of BCD digits (1..6)
//   MAX_COUNT   modulus; the counter runs 0..MAX_COUNT-1 (2..10**NUM_DIGITS)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   en          count enable, one step per enabled edge
//   up          direction: 1 = increment, 0 = decrement
//   clear       synchronous clear to zero
//   load        parallel load strobe
//   load_value  BCD load data, digit i at [4i+3:4i]
//   count       current value in BCD, ones digit at [3:0]
//   carry       high while the enabled step on the coming edge wraps
//   load_err    one-cycle pulse after a rejected load
// ---------------------------------------------------------------------------
module bcd_modulo_counter #(
    parameter int NUM_DIGITS = 2,
    parameter int MAX_COUNT  = 60
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    carry,
    output logic                    load_err
);

    localparam int W = 4 * NUM_DIGITS;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Elaboration-time conversion of a binary constant into packed BCD.
    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic digits_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    if (NUM_DIGITS < 1 || NUM_DIGITS > 6) begin : g_bad_digits
        $error("bcd_modulo_counter: NUM_DIGITS=%0d outside 1..6", NUM_DIGITS);
    end
    if (MAX_COUNT < 2 || MAX_COUNT > pow10(NUM_DIGITS)) begin : g_bad_modulus
        $error("bcd_modulo_counter: MAX_COUNT=%0d outside 2..10**NUM_DIGITS", MAX_COUNT);
    end

    // Terminal value of the count, held as a BCD constant so no binary
    // conversion is ever needed at run time.
    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_COUNT - 1);

    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic         inc_c;
    logic         dec_b;
    logic         at_max;
    logic         at_zero;
    logic         load_ok;
    logic         state_ok;

    // Digit-by-digit BCD ripple for both directions; each digit only uses a
    // 4-bit add/subtract and passes carry or borrow to the next digit up.
    always_comb begin
        inc_val = '0;
        dec_val = '0;
        inc_c   = 1'b1;
        dec_b   = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!inc_c) begin
                inc_val[4*i +: 4] = count[4*i +: 4];
            end else if (count[4*i +: 4] == 4'd9) begin
                inc_val[4*i +: 4] = 4'd0;
            end else begin
                inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
                inc_c = 1'b0;
            end

            if (!dec_b) begin
                dec_val[4*i +: 4] = count[4*i +: 4];
            end else if (count[4*i +: 4] == 4'd0) begin
                dec_val[4*i +: 4] = 4'd9;
            end else begin
                dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
                dec_b = 1'b0;
            end
        end
    end

    assign at_max  = (count == MAX_BCD);
    assign at_zero = (count == '0);

    // For well-formed BCD the packed-vector ordering equals numeric
    // ordering, so the range check is a plain compare against MAX_BCD.
    assign load_ok = digits_valid(load_value) && (load_value <= MAX_BCD);

    assign carry = en & ~load & ~clear & ~rst & (up ? at_max : at_zero);

    // Priority rst > clear > load > en; lower requests are simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            load_err <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            load_err <= 1'b0;
        end else if (load) begin
            if (load_ok) count <= load_value;
            load_err <= ~load_ok;
        end else begin
            load_err <= 1'b0;
            if (en) begin
                if (up) count <= at_max ? '0 : inc_val;
                else    count <= at_zero ? MAX_BCD : dec_val;
            end
        end
    end

    assign state_ok = digits_valid(count) && (count <= MAX_BCD);

    // The count can never leave 0..MAX_COUNT-1 in valid BCD.
    a_state_in_range: assert property (@(posedge clk) disable iff (rst) state_ok);

endmodule

// File: tb/tb_bcd_modulo_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_modulo_counter
//   Directed bench for bcd_modulo_counter: a default 2-digit mod-60 instance,
//   a 3-digit mod-1000 instance and a cascaded seconds/minutes pair.
// ---------------------------------------------------------------------------
module tb_bcd_modulo_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int check_count = 0;
    int error_count = 0;

    // Default instance (2 digits, mod 60)
    logic       rst, en, up, clear, load;
    logic [7:0] load_value, count;
    logic       carry, load_err;

    // 3-digit mod-1000 instance
    logic        en3, up3, load3;
    logic [11:0] load_value3, count3;
    logic        carry3, load_err3;

    // Cascaded seconds -> minutes
    logic       c_en, c_up, c_load;
    logic [7:0] secs_lv, mins_lv, secs_count, mins_count;
    logic       secs_carry, mins_carry, secs_err, mins_err;

    bcd_modulo_counter #(.NUM_DIGITS(2), .MAX_COUNT(60)) u_dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
        .load_value(load_value), .count(count), .carry(carry), .load_err(load_err)
    );

    bcd_modulo_counter #(.NUM_DIGITS(3), .MAX_COUNT(1000)) u_dut3 (
        .clk(clk), .rst(rst), .en(en3), .up(up3), .clear(1'b0), .load(load3),
        .load_value(load_value3), .count(count3), .carry(carry3), .load_err(load_err3)
    );

    bcd_modulo_counter #(.NUM_DIGITS(2), .MAX_COUNT(60)) u_secs (
        .clk(clk), .rst(rst), .en(c_en), .up(c_up), .clear(1'b0), .load(c_load),
        .load_value(secs_lv), .count(secs_count), .carry(secs_carry), .load_err(secs_err)
    );

    bcd_modulo_counter #(.NUM_DIGITS(2), .MAX_COUNT(60)) u_mins (
        .clk(clk), .rst(rst), .en(secs_carry), .up(c_up), .clear(1'b0), .load(c_load),
        .load_value(mins_lv), .count(mins_count), .carry(mins_carry), .load_err(mins_err)
    );

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_value = '0;
        en3 = 1'b0; up3 = 1'b1; load3 = 1'b0; load_value3 = '0;
        c_en = 1'b0; c_up = 1'b1; c_load = 1'b0; secs_lv = '0; mins_lv = '0;

        // Reset
        tick();
        checkOutput("reset_count", 32'(count), 32'h00);
        checkOutput("reset_load_err", 32'(load_err), 32'h0);
        checkOutput("reset_count3", 32'(count3), 32'h000);
        rst = 1'b0;

        // Full up cycle 00..59 then back to 00
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 60; i++) begin
            #1;
            checkOutput($sformatf("up_count_%0d", i), 32'(count), 32'(bcd2(i)));
            checkOutput($sformatf("up_carry_%0d", i), 32'(carry), 32'(i == 59));
            tick();
        end
        checkOutput("up_wrap", 32'(count), 32'h00);
        en = 1'b0;

        // Down from 00 wraps to 59
        load = 1'b1; load_value = 8'h00; en = 1'b1; up = 1'b0;
        tick();
        load = 1'b0;
        #1;
        checkOutput("down_start", 32'(count), 32'h00);
        checkOutput("down_borrow", 32'(carry), 32'h1);
        tick();
        checkOutput("down_wrap", 32'(count), 32'h59);
        checkOutput("down_carry_low", 32'(carry), 32'h0);
        tick();
        checkOutput("down_58", 32'(count), 32'h58);
        tick();
        checkOutput("down_57", 32'(count), 32'h57);

        // Load priority over en, and rejected loads
        load = 1'b1; load_value = 8'h45; en = 1'b1; up = 1'b1;
        tick();
        checkOutput("load_45", 32'(count), 32'h45);
        checkOutput("load_45_err", 32'(load_err), 32'h0);
        load_value = 8'h7A;
        tick();
        checkOutput("load_7A_count", 32'(count), 32'h45);
        checkOutput("load_7A_err", 32'(load_err), 32'h1);
        load = 1'b0; en = 1'b0;
        tick();
        checkOutput("err_pulse_end", 32'(load_err), 32'h0);
        load = 1'b1; load_value = 8'h60;
        tick();
        checkOutput("load_60_count", 32'(count), 32'h45);
        checkOutput("load_60_err", 32'(load_err), 32'h1);
        load = 1'b0;
        tick();
        checkOutput("err_pulse_end2", 32'(load_err), 32'h0);

        // Reset dominates clear, load and en in the same cycle
        load = 1'b1; load_value = 8'h37;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        checkOutput("count_38", 32'(count), 32'h38);
        en = 1'b0; load = 1'b1; load_value = 8'h99;
        tick();
        checkOutput("load_99_err", 32'(load_err), 32'h1);
        rst = 1'b1; clear = 1'b1; load = 1'b1; load_value = 8'h12; en = 1'b1;
        #1;
        checkOutput("rst_carry_low", 32'(carry), 32'h0);
        tick();
        checkOutput("rst_all_count", 32'(count), 32'h00);
        checkOutput("rst_all_err", 32'(load_err), 32'h0);
        rst = 1'b0; clear = 1'b0; load = 1'b0; en = 1'b0;

        // Clear while sitting at 59 with en high suppresses carry
        load = 1'b1; load_value = 8'h58;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        checkOutput("pre_clear_59", 32'(count), 32'h59);
        checkOutput("pre_clear_carry", 32'(carry), 32'h1);
        clear = 1'b1;
        #1;
        checkOutput("clear_carry_low", 32'(carry), 32'h0);
        tick();
        checkOutput("clear_count", 32'(count), 32'h00);
        clear = 1'b0; en = 1'b0;
        tick();
        checkOutput("hold_count", 32'(count), 32'h00);

        // Three digits, mod 1000
        load3 = 1'b1; load_value3 = 12'h999;
        tick();
        load3 = 1'b0; en3 = 1'b1; up3 = 1'b1;
        #1;
        checkOutput("d3_carry_999", 32'(carry3), 32'h1);
        tick();
        checkOutput("d3_wrap", 32'(count3), 32'h000);
        en3 = 1'b0; load3 = 1'b1; load_value3 = 12'h099;
        tick();
        load3 = 1'b0; en3 = 1'b1;
        #1;
        checkOutput("d3_carry_099", 32'(carry3), 32'h0);
        tick();
        checkOutput("d3_ripple_100", 32'(count3), 32'h100);
        up3 = 1'b0;
        tick();
        checkOutput("d3_borrow_099", 32'(count3), 32'h099);
        en3 = 1'b0;

        // Cascaded seconds/minutes
        c_load = 1'b1; secs_lv = 8'h59; mins_lv = 8'h59;
        tick();
        c_load = 1'b0;
        checkOutput("cas_load_secs", 32'(secs_count), 32'h59);
        checkOutput("cas_load_mins", 32'(mins_count), 32'h59);
        c_en = 1'b1; c_up = 1'b1;
        #1;
        checkOutput("cas_secs_carry", 32'(secs_carry), 32'h1);
        checkOutput("cas_mins_carry", 32'(mins_carry), 32'h1);
        tick();
        checkOutput("cas_up_secs", 32'(secs_count), 32'h00);
        checkOutput("cas_up_mins", 32'(mins_count), 32'h00);
        c_up = 1'b0;
        #1;
        checkOutput("cas_borrow", 32'(mins_carry), 32'h1);
        tick();
        checkOutput("cas_down_secs", 32'(secs_count), 32'h59);
        checkOutput("cas_down_mins", 32'(mins_count), 32'h59);
        c_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
